rs422_cmd_dispatch: RTL and testbench
=====================================

// Module: rs422_cmd_dispatch
// PURPOSE
//  Frame parser between the RS422 UART receiver and the 1-to-5 channel mux.
//  Hunts for sync, decodes the destination (TC/HK/SD/DI/PF) into one-hot cmd,
//  streams payload bytes to the selected channel via wen/din under full
//  back-pressure, checks the checksum, then waits for the channel's rx_done.
// PARAMETERS
//  SYNC0        8'hEB    first sync byte
//  SYNC1        8'h90    second sync byte
//  BYTE_TO_CYC  100000   max clk cycles between bytes inside a frame
//  DONE_TO_CYC  1000000  max clk cycles waiting for rx_done after a good frame
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  rx_data    in   8  byte from UART receiver
//  rx_valid   in   1  1-cycle strobe, rx_data valid
//  cmd        out  5  one-hot destination: 00001 TC, 00010 HK, 00100 SD, 01000 DI, 10000 PF
//  wen        out  1  1-cycle write strobe for din
//  din        out  8  payload byte to mux
//  full       in   1  selected channel full (mux returns 1 when cmd invalid)
//  rx_done    in   1  selected channel acknowledges frame complete
//  frame_ok   out  1  1-cycle pulse: frame delivered and acknowledged
//  frame_err  out  1  1-cycle pulse: frame rejected/aborted
//  err_code   out  3  valid with frame_err; held until next frame_err
// BEHAVIOUR
//  Frame: SYNC0 SYNC1 TYPE LEN PAYLOAD[LEN] CHK. TYPE 1..5 -> cmd bit TYPE-1.
//  CHK = (TYPE + LEN + sum payload) mod 256.
//  Reset: state IDLE; cmd=0, wen=0, din=0, frame_ok=0, frame_err=0, err_code=0,
//   checksum, byte counter, timers cleared. All outputs registered.
//  States (advance only on rx_valid unless noted):
//   IDLE: byte==SYNC0 -> S1; else stay.
//   S1: SYNC1 -> TYPE; SYNC0 -> stay S1; other -> IDLE (no error).
//   TYPE: 1..5 -> LEN, cmd set next cycle, sum=TYPE; else err 1, IDLE.
//   LEN: 0 -> err 2, IDLE, cmd=0; else cnt=LEN, sum+=LEN -> PAY.
//   PAY: each byte: sum+=byte, cnt-=1; if full==0 at strobe cycle -> wen=1,
//    din=byte next cycle (latency 1); if full==1 byte dropped, ovf flag set.
//    cnt reaches 0 -> CHK.
//   CHK: ovf -> err 3; else CHK!=sum -> err 4; both -> IDLE, cmd=0.
//    Match -> WAIT; cmd held.
//   WAIT (no rx_valid needed): rx_done==1 -> frame_ok, cmd=0, IDLE;
//    DONE_TO_CYC elapsed -> err 6, cmd=0, IDLE.
//  Inter-byte timer: runs in S1,TYPE,LEN,PAY,CHK; cleared on every rx_valid;
//   reaching BYTE_TO_CYC -> err 5, IDLE, cmd=0, wen not asserted.
//  rx_valid in WAIT: byte dropped, frame_err with err 7, state/cmd unchanged.
//  err_code: 1 bad type, 2 zero len, 3 overflow, 4 checksum, 5 byte timeout,
//   6 done timeout, 7 busy drop. Overflow has priority over checksum.
//  cmd stays 0 outside TYPE..WAIT; stable for whole frame; wen never
//   asserted while cmd==0. At most one of frame_ok/frame_err per cycle.
//  LEN=255 legal; cnt and sum wrap mod 256 by width only.
//  Reset mid-frame: immediate return to IDLE, no pulses emitted.
// TESTING
//  1 EB 90 02 03 11 22 33 6B, full=0, rx_done 5 cyc after CHK -> cmd=00010,
//    3 wen pulses din 11,22,33, frame_ok, cmd=0.
//  2 Same frame, CHK=6C -> 3 wen, frame_err err_code=4, no frame_ok, cmd=0.
//  3 Frame TYPE=05 LEN=02 AA BB, full=1 during BB -> 1 wen (AA), err_code=3.
//  4 EB 90 06 -> err_code=1, no wen; EB 90 01 00 -> err_code=2.
//  5 EB 90 01 02 11 then silence > BYTE_TO_CYC -> err_code=5, cmd=0;
//    good frame with rx_done never high -> err_code=6 after DONE_TO_CYC.
//  6 EB EB 90 04 01 5A 5F (sync re-hunt) -> cmd=01000, 1 wen din=5A;
//    byte during WAIT -> err 7, cmd held; rst mid-PAY -> all outputs 0.

Source files
------------

// File: rtl/rs422_cmd_dispatch.sv
// Frame parser between the RS422 UART receiver and the 1-to-5 channel mux.
// Hunts for the two sync bytes, decodes the destination into a one-hot cmd,
// streams payload bytes to the selected channel under back-pressure, verifies
// the checksum and then waits for the channel to acknowledge the frame.
module rs422_cmd_dispatch #(
    parameter logic [7:0]  SYNC0       = 8'hEB,
    parameter logic [7:0]  SYNC1       = 8'h90,
    parameter int unsigned BYTE_TO_CYC = 100000,
    parameter int unsigned DONE_TO_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [4:0] cmd,
    output logic       wen,
    output logic [7:0] din,
    input  logic       full,
    input  logic       rx_done,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StS1   = 3'd1;
    localparam logic [2:0] StType = 3'd2;
    localparam logic [2:0] StLen  = 3'd3;
    localparam logic [2:0] StPay  = 3'd4;
    localparam logic [2:0] StChk  = 3'd5;
    localparam logic [2:0] StWait = 3'd6;

    localparam int unsigned BtW = $clog2(BYTE_TO_CYC + 1);
    localparam int unsigned DtW = $clog2(DONE_TO_CYC + 1);
    localparam logic [BtW-1:0] BtLast = BtW'(BYTE_TO_CYC - 1);
    localparam logic [DtW-1:0] DtLast = DtW'(DONE_TO_CYC - 1);

    logic [2:0]     state_q, state_d;
    logic [4:0]     cmd_q, cmd_d;
    logic           wen_q, wen_d;
    logic [7:0]     din_q, din_d;
    logic           ok_q, ok_d;
    logic           err_q, err_d;
    logic [2:0]     err_code_q, err_code_d;
    logic [7:0]     sum_q, sum_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic [BtW-1:0] byte_tmr_q, byte_tmr_d;
    logic [DtW-1:0] done_tmr_q, done_tmr_d;

    logic           in_frame;
    logic           abort;
    logic [2:0]     abort_code;

    // Next-state: frame parsing, timers and error/ack pulse generation.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        din_d      = din_q;
        err_code_d = err_code_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        wen_d      = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        byte_tmr_d = '0;
        done_tmr_d = '0;
        abort      = 1'b0;
        abort_code = 3'd0;

        // Inter-byte timer only runs while a frame is being received.
        in_frame = (state_q >= StS1) && (state_q <= StChk);
        if (in_frame && !rx_valid) begin
            if (byte_tmr_q == BtLast) begin
                abort      = 1'b1;
                abort_code = 3'd5;
            end else begin
                byte_tmr_d = byte_tmr_q + BtW'(1);
            end
        end

        if (!abort) begin
            case (state_q)
                StIdle: begin
                    if (rx_valid && rx_data == SYNC0) state_d = StS1;
                end
                StS1: begin
                    if (rx_valid) begin
                        if (rx_data == SYNC1)      state_d = StType;
                        else if (rx_data != SYNC0) state_d = StIdle;
                    end
                end
                StType: begin
                    if (rx_valid) begin
                        if (rx_data >= 8'd1 && rx_data <= 8'd5) begin
                            state_d = StLen;
                            cmd_d   = 5'd1 << (rx_data[2:0] - 3'd1);
                            sum_d   = rx_data;
                        end else begin
                            abort      = 1'b1;
                            abort_code = 3'd1;
                        end
                    end
                end
                StLen: begin
                    if (rx_valid) begin
                        if (rx_data == 8'd0) begin
                            abort      = 1'b1;
                            abort_code = 3'd2;
                        end else begin
                            cnt_d   = rx_data;
                            sum_d   = sum_q + rx_data;
                            ovf_d   = 1'b0;
                            state_d = StPay;
                        end
                    end
                end
                StPay: begin
                    if (rx_valid) begin
                        sum_d = sum_q + rx_data;
                        cnt_d = cnt_q - 8'd1;
                        // A full channel loses the byte; the frame is doomed.
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            wen_d = 1'b1;
                            din_d = rx_data;
                        end
                        if (cnt_q == 8'd1) state_d = StChk;
                    end
                end
                StChk: begin
                    if (rx_valid) begin
                        if (ovf_q) begin
                            abort      = 1'b1;
                            abort_code = 3'd3;
                        end else if (rx_data != sum_q) begin
                            abort      = 1'b1;
                            abort_code = 3'd4;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    // Ack wins over a stray byte; timeout wins over a stray byte.
                    if (rx_done) begin
                        ok_d    = 1'b1;
                        cmd_d   = 5'd0;
                        state_d = StIdle;
                    end else if (done_tmr_q == DtLast) begin
                        abort      = 1'b1;
                        abort_code = 3'd6;
                    end else begin
                        done_tmr_d = done_tmr_q + DtW'(1);
                        if (rx_valid) begin
                            err_d      = 1'b1;
                            err_code_d = 3'd7;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (abort) begin
            state_d    = StIdle;
            cmd_d      = 5'd0;
            wen_d      = 1'b0;
            err_d      = 1'b1;
            err_code_d = abort_code;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cmd_q      <= 5'd0;
            wen_q      <= 1'b0;
            din_q      <= 8'd0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
            sum_q      <= 8'd0;
            cnt_q      <= 8'd0;
            ovf_q      <= 1'b0;
            byte_tmr_q <= '0;
            done_tmr_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            wen_q      <= wen_d;
            din_q      <= din_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            byte_tmr_q <= byte_tmr_d;
            done_tmr_q <= done_tmr_d;
        end
    end

    assign cmd       = cmd_q;
    assign wen       = wen_q;
    assign din       = din_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_rs422_cmd_dispatch.sv
// Bench for rs422_cmd_dispatch: a frame-buffer reference model predicts every
// output each cycle; directed frames pin the model with literal expectations,
// then randomized frames exercise errors, back-pressure and timeouts.
module tb_rs422_cmd_dispatch;

    localparam int unsigned BYTE_TO = 50;
    localparam int unsigned DONE_TO = 80;
    localparam logic [7:0]  SYNC0   = 8'hEB;
    localparam logic [7:0]  SYNC1   = 8'h90;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       full = 1'b0;
    logic       rx_done = 1'b0;
    logic [4:0] cmd;
    logic       wen;
    logic [7:0] din;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;

    rs422_cmd_dispatch #(
        .SYNC0      (SYNC0),
        .SYNC1      (SYNC1),
        .BYTE_TO_CYC(BYTE_TO),
        .DONE_TO_CYC(DONE_TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cmd      (cmd),
        .wen      (wen),
        .din      (din),
        .full     (full),
        .rx_done  (rx_done),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the bytes of the frame accepted so far.
    logic [7:0] frame[$];
    bit         waiting = 1'b0;
    bit         ovf = 1'b0;
    int         gap = 0;
    int         wait_cnt = 0;
    logic [4:0] e_cmd = '0;
    logic       e_wen = 1'b0;
    logic [7:0] e_din = '0;
    logic       e_ok = 1'b0;
    logic       e_err = 1'b0;
    logic [2:0] e_code = '0;

    // Observed traffic for the directed checks.
    logic [7:0] wen_log[$];
    int         ok_cnt = 0;
    int         err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_abort(input logic [2:0] code);
        e_err  = 1'b1;
        e_code = code;
        e_cmd  = '0;
        e_wen  = 1'b0;
        waiting = 1'b0;
        frame.delete();
    endtask

    task automatic m_accept(input logic [7:0] b);
        int n;
        int len;
        int s;
        n = frame.size();
        if (n == 0) begin
            if (b == SYNC0) frame.push_back(b);
        end else if (n == 1) begin
            if (b == SYNC1) frame.push_back(b);
            else if (b != SYNC0) frame.delete();
        end else if (n == 2) begin
            if (b >= 1 && b <= 5) begin
                frame.push_back(b);
                e_cmd = 5'd1 << (b - 1);
            end else begin
                m_abort(3'd1);
            end
        end else if (n == 3) begin
            if (b == 0) m_abort(3'd2);
            else begin
                frame.push_back(b);
                ovf = 1'b0;
            end
        end else begin
            len = int'(frame[3]);
            if (n < 4 + len) begin
                frame.push_back(b);
                if (full) ovf = 1'b1;
                else begin
                    e_wen = 1'b1;
                    e_din = b;
                end
            end else begin
                s = 0;
                for (int i = 2; i < frame.size(); i++) s += int'(frame[i]);
                if (ovf) m_abort(3'd3);
                else if ((s % 256) != int'(b)) m_abort(3'd4);
                else begin
                    waiting  = 1'b1;
                    wait_cnt = 0;
                end
            end
        end
    endtask

    // Advance the model on each clock using the inputs the DUT samples.
    always @(posedge clk) begin
        if (rst) begin
            frame.delete();
            waiting = 1'b0;
            ovf = 1'b0;
            gap = 0;
            wait_cnt = 0;
            e_cmd = '0;
            e_wen = 1'b0;
            e_din = '0;
            e_ok = 1'b0;
            e_err = 1'b0;
            e_code = '0;
        end else begin
            e_wen = 1'b0;
            e_ok  = 1'b0;
            e_err = 1'b0;
            if (waiting) begin
                if (rx_done) begin
                    e_ok    = 1'b1;
                    e_cmd   = '0;
                    waiting = 1'b0;
                    frame.delete();
                end else if (wait_cnt + 1 == int'(DONE_TO)) begin
                    m_abort(3'd6);
                end else begin
                    wait_cnt++;
                    if (rx_valid) begin
                        e_err  = 1'b1;
                        e_code = 3'd7;
                    end
                end
            end else if (rx_valid) begin
                gap = 0;
                m_accept(rx_data);
            end else if (frame.size() != 0) begin
                gap++;
                if (gap == int'(BYTE_TO)) m_abort(3'd5);
            end
        end
    end

    // Compare all outputs against the model every cycle.
    always @(posedge clk) begin
        #1;
        check("cmd", cmd, e_cmd);
        check("wen", wen, e_wen);
        check("din", din, e_din);
        check("frame_ok", frame_ok, e_ok);
        check("frame_err", frame_err, e_err);
        check("err_code", err_code, e_code);
        check("one_pulse", frame_ok & frame_err, 1'b0);
        if (wen) wen_log.push_back(din);
        if (frame_ok) ok_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic send(input logic [7:0] b, input logic f, input int g);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        full     = f;
        @(negedge clk);
        rx_valid = 1'b0;
        full     = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic clear_logs();
        wen_log.delete();
        ok_cnt  = 0;
        err_cnt = 0;
    endtask

    function automatic logic [7:0] log_at(input int i);
        if (i < wen_log.size()) return wen_log[i];
        return 8'hxx;
    endfunction

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i], 1'b0, 0);
    endtask

    initial begin
        logic [7:0] typ;
        logic [7:0] len;
        logic [7:0] chk;
        int         s;
        int         r;

        idle(3);
        rst = 1'b0;
        idle(1);
        check("reset_cmd", cmd, 5'd0);
        check("reset_err_code", err_code, 3'd0);
        check("reset_pulses", {wen, frame_ok, frame_err}, 3'b000);

        // Good HK frame, ack after a few cycles.
        clear_logs();
        send_list('{8'hEB, 8'h90, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B});
        idle(1);
        check("t1_cmd_hk", cmd, 5'b00010);
        idle(4);
        pulse_done();
        idle(1);
        check("t1_wen_count", wen_log.size(), 3);
        check("t1_din_seq", {log_at(0), log_at(1), log_at(2)}, 24'h112233);
        check("t1_ok_count", ok_cnt, 1);
        check("t1_err_count", err_cnt, 0);
        check("t1_cmd_end", cmd, 5'd0);

        // Same frame with a bad checksum.
        clear_logs();
        send_list('{8'hEB, 8'h90, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6C});
        idle(2);
        check("t2_wen_count", wen_log.size(), 3);
        check("t2_err_code", err_code, 3'd4);
        check("t2_ok_count", ok_cnt, 0);
        check("t2_cmd", cmd, 5'd0);

        // Overflow: channel full during second payload byte.
        clear_logs();
        send_list('{8'hEB, 8'h90, 8'h05, 8'h02, 8'hAA});
        check("t3_cmd_pf", cmd, 5'b10000);
        send(8'hBB, 1'b1, 0);
        send(8'h6C, 1'b0, 0);
        idle(2);
        check("t3_wen_count", wen_log.size(), 1);
        check("t3_din", log_at(0), 8'hAA);
        check("t3_err_code", err_code, 3'd3);

        // Bad type, then zero length.
        clear_logs();
        send_list('{8'hEB, 8'h90, 8'h06});
        idle(2);
        check("t4_bad_type", err_code, 3'd1);
        check("t4_no_wen", wen_log.size(), 0);
        send_list('{8'hEB, 8'h90, 8'h01, 8'h00});
        idle(2);
        check("t4_zero_len", err_code, 3'd2);
        check("t4_cmd", cmd, 5'd0);

        // Inter-byte timeout, then ack timeout.
        clear_logs();
        send_list('{8'hEB, 8'h90, 8'h01, 8'h02, 8'h11});
        idle(2);
        check("t5_cmd_tc", cmd, 5'b00001);
        idle(BYTE_TO + 5);
        check("t5_byte_to", err_code, 3'd5);
        check("t5_cmd", cmd, 5'd0);
        send_list('{8'hEB, 8'h90, 8'h01, 8'h01, 8'h77, 8'h79});
        idle(DONE_TO + 5);
        check("t5_done_to", err_code, 3'd6);
        check("t5_no_ok", ok_cnt, 0);

        // Sync re-hunt, busy drop, then reset mid-payload.
        clear_logs();
        send_list('{8'hEB, 8'hEB, 8'h90, 8'h04, 8'h01, 8'h5A, 8'h5F});
        idle(2);
        check("t6_cmd_di", cmd, 5'b01000);
        check("t6_din", log_at(0), 8'h5A);
        send(8'h33, 1'b0, 0);
        check("t6_busy_code", err_code, 3'd7);
        check("t6_cmd_held", cmd, 5'b01000);
        pulse_done();
        idle(1);
        check("t6_ok_count", ok_cnt, 1);
        send_list('{8'hEB, 8'h90, 8'h03, 8'h04, 8'h01, 8'h02});
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", {cmd, wen, din, frame_ok, frame_err, err_code}, 19'd0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)), 1'b0, 1);
            typ = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(1, 5));
            if (f == 30) len = 8'd255;
            else if ($urandom_range(0, 11) == 0) len = 8'd0;
            else len = 8'($urandom_range(1, 6));
            s = int'(typ) + int'(len);
            send(SYNC0, 1'b0, $urandom_range(0, 2));
            send(SYNC1, 1'b0, $urandom_range(0, 2));
            send(typ, 1'b0, $urandom_range(0, 2));
            send(len, 1'b0, $urandom_range(0, 2));
            for (int i = 0; i < int'(len); i++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                s += int'(b);
                send(b, ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 40) == 0) ? int'(BYTE_TO) + 3 : $urandom_range(0, 2));
            end
            chk = 8'(s);
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            send(chk, 1'b0, 2);
            if (waiting) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    idle(DONE_TO + 2);
                end else if (r == 1) begin
                    send(8'($urandom_range(0, 255)), 1'b0, $urandom_range(0, 3));
                    pulse_done();
                end else begin
                    idle($urandom_range(0, 8));
                    pulse_done();
                end
            end
            idle(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
